// File: rtl/mc_datapath_pkg.sv
// Shared types and constants for the multicycle datapath: FSM states,
// decoder control-word field positions, immediate and ALU operation codes.
package mc_datapath_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam int CTL_PCSRC     = 12;
  localparam int CTL_MEMTOREG  = 11;
  localparam int CTL_MEMWRITE  = 10;
  localparam int CTL_ALU_HI    = 9;
  localparam int CTL_ALU_LO    = 6;
  localparam int CTL_ALUSRC    = 5;
  localparam int CTL_IMM_HI    = 4;
  localparam int CTL_IMM_LO    = 3;
  localparam int CTL_REGWRITE  = 2;
  localparam int CTL_REGSRC_HI = 1;
  localparam int CTL_REGSRC_LO = 0;

  localparam logic [1:0] IMM_ZX8  = 2'b00;
  localparam logic [1:0] IMM_ZX12 = 2'b01;
  localparam logic [1:0] IMM_BR24 = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_ORR = 4'h3;
  localparam logic [3:0] ALU_EOR = 4'h4;
  localparam logic [3:0] ALU_MOV = 4'h5;

  localparam logic [3:0] R15 = 4'd15;

endpackage

// File: rtl/mc_regfile.sv
// Architectural register file: two async read ports, one sync write port.
// Index 15 is not stored; it reads as PC+8 (modulo 2^PC_W), zero-extended.
module mc_regfile
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 13,
  parameter int NREGS  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        ra1_i,
  input  logic [3:0]        ra2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              we_i,
  input  logic [3:0]        wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [PC_W-1:0]   pc_i
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [PC_W-1:0]   pc_plus8;

  assign pc_plus8 = pc_i + PC_W'(8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != R15) && (int'(wa_i) < NREGS)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = '0;
    if (ra1_i == R15)               rd1_o = DATA_W'(pc_plus8);
    else if (int'(ra1_i) < NREGS)   rd1_o = regs_q[ra1_i];
  end

  always_comb begin
    rd2_o = '0;
    if (ra2_i == R15)               rd2_o = DATA_W'(pc_plus8);
    else if (int'(ra2_i) < NREGS)   rd2_o = regs_q[ra2_i];
  end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath: FETCH -> DECODE -> EXEC -> (MEM) -> WB over handshaked
// instruction and data ports; control word comes from an external decoder.
module mc_datapath
  import mc_datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 13,
  parameter int NREGS    = 15,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [12:0]       Control,
  output logic [19:0]       InstrControl,
  output logic [3:0]        ALUFlags,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              instr_done
);

  localparam int MSB = DATA_W - 1;

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, aluout_q, mdr_q;
  logic [3:0]        flags_q;

  logic              pcsrc, memtoreg, memwrite, alusrc, regwrite;
  logic [3:0]        alu_op;
  logic [1:0]        immsrc, regsrc;
  logic [3:0]        ra1, ra2;
  logic [DATA_W-1:0] rd1, rd2, ext_imm, src_b, result;
  logic [DATA_W-1:0] alu_res, br_imm;
  logic [DATA_W:0]   sum;
  logic              alu_c, alu_v;
  logic [PC_W-1:0]   pc_plus4;

  assign pcsrc    = Control[CTL_PCSRC];
  assign memtoreg = Control[CTL_MEMTOREG];
  assign memwrite = Control[CTL_MEMWRITE];
  assign alu_op   = Control[CTL_ALU_HI:CTL_ALU_LO];
  assign alusrc   = Control[CTL_ALUSRC];
  assign immsrc   = Control[CTL_IMM_HI:CTL_IMM_LO];
  assign regwrite = Control[CTL_REGWRITE];
  assign regsrc   = Control[CTL_REGSRC_HI:CTL_REGSRC_LO];

  assign ra1 = regsrc[0] ? R15 : ir_q[19:16];
  assign ra2 = regsrc[1] ? ir_q[15:12] : ir_q[3:0];

  mc_regfile #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (ra1),
    .ra2_i (ra2),
    .rd1_o (rd1),
    .rd2_o (rd2),
    .we_i  ((state_q == S_WB) && regwrite),
    .wa_i  (ir_q[15:12]),
    .wd_i  (result),
    .pc_i  (pc_q)
  );

  assign br_imm = {{(DATA_W-24){ir_q[23]}}, ir_q[23:0]};

  always_comb begin
    ext_imm = '0;
    case (immsrc)
      IMM_ZX8:  ext_imm = DATA_W'(ir_q[7:0]);
      IMM_ZX12: ext_imm = DATA_W'(ir_q[11:0]);
      IMM_BR24: ext_imm = br_imm << 2;
      default:  ext_imm = '0;
    endcase
  end

  assign src_b = alusrc ? ext_imm : b_q;

  // Unrecognised ALU codes fall back to ADD.
  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      ALU_SUB: begin
        sum     = {1'b0, a_q} + {1'b0, ~src_b} + (DATA_W+1)'(1);
        alu_res = sum[MSB:0];
        alu_c   = sum[DATA_W];
        alu_v   = (a_q[MSB] != src_b[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
      ALU_AND: alu_res = a_q & src_b;
      ALU_ORR: alu_res = a_q | src_b;
      ALU_EOR: alu_res = a_q ^ src_b;
      ALU_MOV: alu_res = src_b;
      default: begin
        sum     = {1'b0, a_q} + {1'b0, src_b};
        alu_res = sum[MSB:0];
        alu_c   = sum[DATA_W];
        alu_v   = (a_q[MSB] == src_b[MSB]) && (alu_res[MSB] != a_q[MSB]);
      end
    endcase
  end

  assign result   = memtoreg ? mdr_q : aluout_q;
  assign pc_plus4 = pc_q + PC_W'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_W'(RESET_PC);
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ready) begin
            ir_q    <= imem_rdata;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q     <= rd1;
          b_q     <= rd2;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          aluout_q <= alu_res;
          flags_q  <= {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
          state_q  <= (memwrite || memtoreg) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (memwrite) begin
              pc_q    <= pc_plus4;
              state_q <= S_FETCH;
            end else begin
              mdr_q   <= dmem_rdata;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          pc_q    <= pcsrc ? result[PC_W-1:0] : pc_plus4;
          state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Reset parks the FSM in FETCH, so the fetch request is also gated by rst.
  assign imem_req     = (state_q == S_FETCH) && !rst;
  assign imem_addr    = pc_q;
  assign InstrControl = ir_q[31:12];
  assign ALUFlags     = flags_q;
  assign dmem_req     = (state_q == S_MEM);
  assign dmem_we      = (state_q == S_MEM) && memwrite;
  assign dmem_addr    = aluout_q;
  assign dmem_wdata   = b_q;
  assign instr_done   = (state_q == S_WB) ||
                        ((state_q == S_MEM) && dmem_ready && memwrite);

endmodule

// File: tb/tb_mc_datapath.sv
// Directed plus randomized bench for mc_datapath with an instruction-level
// reference model of registers, PC and flags.
module tb_mc_datapath;

  localparam int DATA_W = 32;
  localparam int PC_W   = 13;
  localparam int NREGS  = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [12:0]       Control;
  logic [19:0]       InstrControl;
  logic [3:0]        ALUFlags;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ready;
  logic              dmem_req, dmem_we;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic              dmem_ready;
  logic              instr_done;

  mc_datapath #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(NREGS), .RESET_PC(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .Control      (Control),
    .InstrControl (InstrControl),
    .ALUFlags     (ALUFlags),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ready   (dmem_ready),
    .instr_done   (instr_done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0]     m_regs [NREGS];
  logic [PC_W-1:0] m_pc;
  logic [3:0]      m_flags;

  // per-instruction expectations
  logic [31:0]     e_alu, e_wdata, e_wval;
  logic [3:0]      e_flags;
  logic [PC_W-1:0] e_pc;
  int              e_wr;
  logic            e_mem, e_we;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [12:0] mk_ctrl(input bit pcsrc, input bit mtr, input bit mw,
                                          input logic [3:0] op, input bit asrc,
                                          input logic [1:0] isrc, input bit rw,
                                          input logic [1:0] rs);
    return {pcsrc, mtr, mw, op, asrc, isrc, rw, rs};
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    longint v;
    if (idx == 4'd15) begin
      v = (longint'(m_pc) + 8) % 8192;
      return 32'(v);
    end
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_pc    = '0;
    m_flags = '0;
  endtask

  task automatic predict(input logic [31:0] ins, input logic [12:0] c, input logic [31:0] ld);
    logic [31:0] a, b, imm, sb, res, rslt;
    longint ua, ub, sa, sbs, r, sr, s24;
    bit cf, vf;
    a = m_read(c[0] ? 4'd15 : ins[19:16]);
    b = m_read(c[1] ? ins[15:12] : ins[3:0]);
    case (c[4:3])
      2'd0: imm = {24'd0, ins[7:0]};
      2'd1: imm = {20'd0, ins[11:0]};
      2'd2: begin
        s24 = longint'(ins[23:0]);
        if (ins[23]) s24 = s24 - (longint'(1) << 24);
        imm = 32'(s24 * 4);
      end
      default: imm = '0;
    endcase
    sb  = c[5] ? imm : b;
    ua  = longint'(a);
    ub  = longint'(sb);
    sa  = longint'($signed(a));
    sbs = longint'($signed(sb));
    cf  = 0;
    vf  = 0;
    case (c[9:6])
      4'h1: begin
        r  = ua - ub;
        cf = (ua >= ub);
        sr = sa - sbs;
        vf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'h2: r = longint'(a & sb);
      4'h3: r = longint'(a | sb);
      4'h4: r = longint'(a ^ sb);
      4'h5: r = longint'(sb);
      default: begin
        r  = ua + ub;
        cf = (r > 64'sd4294967295);
        sr = sa + sbs;
        vf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
    endcase
    res     = 32'(r);
    e_alu   = res;
    e_flags = {res[31], res == 32'd0, cf, vf};
    e_wdata = b;
    e_mem   = c[10] | c[11];
    e_we    = c[10];
    rslt    = c[11] ? ld : res;
    e_wval  = rslt;
    e_wr    = -1;
    if (c[10]) e_pc = PC_W'((longint'(m_pc) + 4) % 8192);
    else begin
      e_pc = c[12] ? rslt[PC_W-1:0] : PC_W'((longint'(m_pc) + 4) % 8192);
      if (c[2] && ins[15:12] != 4'd15) e_wr = int'(ins[15:12]);
    end
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ins, input logic [12:0] c,
                           input int iw, input int dw, input logic [31:0] ld);
    int cyc, lat, iwl, dwl;
    bit done;
    predict(ins, c, ld);
    lat = 4 + iw;
    if (c[10]) lat += dw;
    else if (c[11]) lat += 1 + dw;
    Control = c;
    iwl = iw;
    dwl = dw;
    cyc = 0;
    done = 0;
    while (!done && cyc < 40) begin
      cyc++;
      if (imem_req) begin
        chk({tag, ":fetch_addr"}, 64'(imem_addr), 64'(m_pc));
        imem_rdata = ins;
        imem_ready = (iwl == 0);
        if (iwl > 0) iwl--;
      end else begin
        imem_rdata = $urandom;
        imem_ready = 1'($urandom % 2);
      end
      if (dmem_req) begin
        chk({tag, ":dmem_we"}, 64'(dmem_we), 64'(e_we));
        chk({tag, ":dmem_addr"}, 64'(dmem_addr), 64'(e_alu));
        if (e_we) chk({tag, ":dmem_wdata"}, 64'(dmem_wdata), 64'(e_wdata));
        dmem_rdata = ld;
        dmem_ready = (dwl == 0);
        if (dwl > 0) dwl--;
      end else begin
        dmem_rdata = $urandom;
        dmem_ready = 1'($urandom % 2);
      end
      #1;
      done = instr_done;
      @(negedge clk);
    end
    chk({tag, ":latency"}, 64'(cyc), 64'(lat));
    if (e_wr >= 0) m_regs[e_wr] = e_wval;
    m_pc    = e_pc;
    m_flags = e_flags;
    chk({tag, ":instr_ctl"}, 64'(InstrControl), 64'(ins[31:12]));
    chk({tag, ":flags"}, 64'(ALUFlags), 64'(m_flags));
    chk({tag, ":next_pc"}, 64'(imem_addr), 64'(m_pc));
    chk({tag, ":next_req"}, 64'(imem_req), 64'd1);
    for (int i = 0; i < NREGS; i++)
      chk({tag, ":reg"}, 64'(dut.u_rf.regs_q[i]), 64'(m_regs[i]));
  endtask

  initial begin
    logic [12:0] c_add, c_str, c_ldr, c_br, c;
    logic [31:0] ins, diff;
    int kind;

    rst = 1'b1;
    Control = '0;
    imem_rdata = '0;
    imem_ready = 1'b1;
    dmem_rdata = '0;
    dmem_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_done", 64'(instr_done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_imem_req", 64'(imem_req), 64'd1);
    chk("rel_imem_addr", 64'(imem_addr), 64'd0);
    chk("rel_ir", 64'(dut.ir_q), 64'd0);
    chk("rel_flags", 64'(ALUFlags), 64'd0);
    chk("rel_done", 64'(instr_done), 64'd0);

    c_add = mk_ctrl(0, 0, 0, 4'h0, 1, 2'b00, 1, 2'b01);
    c_str = mk_ctrl(0, 0, 1, 4'h0, 1, 2'b01, 0, 2'b10);
    c_ldr = mk_ctrl(0, 1, 0, 4'h0, 1, 2'b01, 1, 2'b00);
    c_br  = mk_ctrl(1, 0, 0, 4'h0, 1, 2'b10, 0, 2'b01);

    run_instr("add_r15", 32'hE28F1004, c_add, 0, 0, 0);
    chk("add_r1_is_12", 64'(dut.u_rf.regs_q[1]), 64'd12);
    run_instr("add_iwait", 32'hE28F1004, c_add, 3, 0, 0);
    run_instr("str", 32'hE5801040, c_str, 0, 0, 0);
    run_instr("ldr", 32'hE5902040, c_ldr, 0, 0, 32'd12);
    run_instr("str_dwait", 32'hE5801040, c_str, 1, 2, 0);
    run_instr("ldr_dwait", 32'hE5902040, c_ldr, 0, 3, 32'hCAFE_0012);
    run_instr("branch", 32'hEA000002, c_br, 0, 0, 0);

    // branch to the top of the PC space, then check the wrap on PC+8 and PC+4
    diff = 32'((longint'(13'h1FFC) - longint'(m_pc) - 8 + 8192) % 8192);
    run_instr("br_top", 32'hEA000000 | (diff >> 2), c_br, 0, 0, 0);
    chk("at_top", 64'(imem_addr), 64'h1FFC);
    run_instr("wrap", 32'hE28F3000, c_add, 0, 0, 0);
    chk("wrap_pc", 64'(imem_addr), 64'd0);
    chk("wrap_r3", 64'(dut.u_rf.regs_q[3]), 64'd4);
    run_instr("sub_neg", 32'hE24F1FFF, mk_ctrl(0, 0, 0, 4'h1, 1, 2'b01, 1, 2'b01), 0, 0, 0);

    for (int k = 0; k < 50; k++) begin
      ins  = $urandom;
      kind = int'($urandom % 4);
      case (kind)
        0: c = mk_ctrl(0, 0, 0, 4'($urandom % 6), 1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));
        1: c = mk_ctrl(0, 0, 1, 4'($urandom % 6), 1'($urandom), 2'($urandom), 0, 2'($urandom));
        2: c = mk_ctrl(0, 1, 0, 4'($urandom % 6), 1'($urandom), 2'($urandom), 1, 2'($urandom));
        default: c = mk_ctrl(1, 0, 0, 4'($urandom % 6), 1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));
      endcase
      run_instr("rand", ins, c, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom);
    end

    // async reset while a load is stalled in MEM
    Control    = c_ldr;
    imem_rdata = 32'hE5902040;
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_mem_req", 64'(dmem_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_mid_imem_req", 64'(imem_req), 64'd0);
    chk("rst_mid_pc", 64'(imem_addr), 64'd0);
    chk("rst_mid_done", 64'(instr_done), 64'd0);
    chk("rst_mid_flags", 64'(ALUFlags), 64'd0);
    model_reset();
    for (int i = 0; i < NREGS; i++)
      chk("rst_mid_reg", 64'(dut.u_rf.regs_q[i]), 64'd0);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_imem_req", 64'(imem_req), 64'd1);
    chk("post_rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("post_rst_pc", 64'(imem_addr), 64'd0);
    run_instr("post_rst_add", 32'hE28F1004, c_add, 0, 0, 0);
    chk("post_rst_r2", 64'(dut.u_rf.regs_q[2]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
Name: mc_datapath

Overview:
Parametrised multicycle successor to the single-cycle datapath. It shares one handshaked instruction port and one handshaked data port with variable-latency memories, and sequences each instruction through an internal step FSM. The external decoder still receives IR[31:12] and returns the 13-bit control word. ALU flags are registered for the external condition logic.

Parameters:
DATA_W, 32, datapath and register width
PC_W, 13, program counter / instruction address width
NREGS, 15, architectural registers R0..NREGS-1 held in file; index 15 reads PC+8
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
Control  in  13  decoder word: [12]PCSrc [11]MemtoReg [10]MemWrite [9:6]ALUControl [5]ALUSrc [4:3]ImmSrc [2]RegWrite [1:0]RegSrc
InstrControl  out  20  IR[31:12] to decoder
ALUFlags  out  4  registered NZCV
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  fetch address (= PC)
imem_rdata  in  32  fetched instruction
imem_ready  in  1  fetch data valid this cycle
dmem_req  out  1  data access request
dmem_we  out  1  1 = store
dmem_addr  out  DATA_W  data address (= ALUOut)
dmem_wdata  out  DATA_W  store data (= B latch)
dmem_rdata  in  DATA_W  load data
dmem_ready  in  1  data access complete this cycle
instr_done  out  1  one-cycle pulse when an instruction retires

Behaviour:
- Reset (async): state FETCH; PC=RESET_PC; IR, A, B, ALUOut, MDR, all registers, and ALUFlags = 0. Reset holds imem_req, dmem_req, dmem_we, and instr_done at 0. First post-reset cycle: imem_req=1, imem_addr=RESET_PC.
- States: FETCH, DECODE, EXEC, MEM, WB.
- FETCH: imem_req=1, imem_addr=PC. Both are held stable until imem_ready, which may be high in the same cycle as the request. On ready: IR<=imem_rdata, go to DECODE.
- DECODE: InstrControl=IR[31:12]. Control is valid from DECODE through the end of the instruction.
  - RA1 = RegSrc[0] ? 15 : IR[19:16].
  - RA2 = RegSrc[1] ? IR[15:12] : IR[3:0].
  - Latch A<=RD(RA1), B<=RD(RA2); a read of index 15 returns PC+8, zero-extended.
  - Go to EXEC.
- EXEC: SrcB = ALUSrc ? ExtImm : B.
  - ExtImm by ImmSrc: 00 = zext IR[7:0]; 01 = zext IR[11:0]; 10 = sext(IR[23:0])<<2, all to DATA_W; 11 = 0.
  - ALUOut<=ALU(A,SrcB,ALUControl); ALUFlags<=flags, every instruction.
  - Next state: MEM if MemWrite|MemtoReg, else WB.
- MEM: dmem_req=1, dmem_we=MemWrite, addr/wdata held stable until dmem_ready.
  - On ready with a load: MDR<=dmem_rdata, go to WB.
  - On ready with a store: retire (PC update, instr_done=1), go to FETCH.
- WB: Result = MemtoReg ? MDR : ALUOut.
  - If RegWrite and IR[15:12]!=15: reg[IR[15:12]]<=Result. Writes to 15 never touch the file.
  - PC <= PCSrc ? Result[PC_W-1:0] : PC+4. instr_done=1. Go to FETCH.
- PC+4 and PC+8 wrap modulo 2^PC_W.
- Latency with zero-wait memories: ALU/branch 4 cycles, store 4, load 5. Each wait cycle adds 1.
- Ready outside its matching request is ignored. A response still pending when reset is asserted is discarded.
- Reset asserted mid-instruction: all requests drop immediately without waiting for a clock edge. No partial register or PC write survives.

Decomposition:
- mc_datapath_pkg: state enum; Control field bit positions; ImmSrc codes; R15 index constant.
- Sub-module mc_regfile: NREGS x DATA_W, two async read ports, one sync write port, async reset, index-15 bypass to PC+8.
- Existing ALU and extend blocks are reused with DATA_W parameter.

Test Plan:
- Reset release with imem_ready=1 -> cycle 1: imem_req=1, imem_addr=0; IR=0, ALUFlags=0, instr_done=0.
- At PC=0: ADD R1,R15,#4 (ALUSrc=1, ImmSrc=00, RegSrc=01, RegWrite=1), zero-wait -> R1=12, instr_done in cycle 4, PC=4.
- Same ADD with imem_ready low for 3 cycles -> imem_req/imem_addr stable throughout; instr_done in cycle 7; R1=12.
- STR R1 -> dmem_req=1, dmem_we=1, addr 0x40, wdata 12, 4 cycles. LDR R2 with dmem_rdata=12 -> dmem_we=0, R2=12, 5 cycles.
- Branch at PC=8: PCSrc=1, ImmSrc=10, imm24=2, A=R15 -> next imem_addr=24. With PC=0x1FFC and no branch -> next PC=0.
- rst pulsed mid-MEM while dmem_req=1 -> dmem_req=0 before the next edge; PC=0; R1/R2=0; the late dmem_ready is ignored.
